// File: rtl/ifu_fetch.sv
// Instruction fetch unit: sequential word fetches on a valid/ready bus, with in-order
// responses buffered in a small FIFO and handed to execute as {pc, ir} packets.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        o_fch_req_vld,
   input  logic        i_fch_req_rdy,
   output logic [31:0] o_fch_req_addr,
   input  logic        i_fch_rsp_vld,
   input  logic [31:0] i_fch_rsp_data,
   input  logic        i_redir_vld,
   input  logic [31:0] i_redir_pc,
   output logic        o_iexec_req_vld,
   input  logic        i_iexec_req_rdy,
   output logic [31:0] o_iexec_req_pc,
   output logic [31:0] o_iexec_req_ir
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic {ST_BOOT, ST_RUN} state_t;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
   } pkt_t;

   state_t           r_state, w_state_nxt;
   logic [31:0]      r_fetch_pc, r_rsp_pc;
   logic [CNT_W-1:0] r_inflight, r_drop, r_cnt;
   logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
   pkt_t             r_mem [FIFO_DEPTH];
   logic             w_req_hsk, w_push, w_pop;
   logic [SUM_W-1:0] w_used;
   logic [31:0]      w_redir_pc;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign o_fch_req_addr  = r_fetch_pc;
   assign o_iexec_req_vld = (r_cnt != '0);
   assign o_iexec_req_pc  = r_mem[r_rd_ptr].pc;
   assign o_iexec_req_ir  = r_mem[r_rd_ptr].ir;

   assign w_redir_pc = {i_redir_pc[31:2], 2'b00};
   assign w_pop      = o_iexec_req_vld && i_iexec_req_rdy;
   assign w_req_hsk  = o_fch_req_vld && i_fch_req_rdy;
   assign w_push     = i_fch_rsp_vld && (r_drop == '0) && !i_redir_vld;
   // A slot freed by this cycle's pop counts as credit, so a 1-cycle bus streams.
   assign w_used     = SUM_W'(r_inflight) + SUM_W'(r_cnt) - SUM_W'(w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_BOOT;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      o_fch_req_vld = 1'b0;
      case (r_state)
         ST_BOOT: w_state_nxt = ST_RUN;
         ST_RUN:  o_fch_req_vld = !i_redir_vld && (w_used < SUM_W'(FIFO_DEPTH));
      endcase
   end

   // Fetch/response PCs, outstanding and stale counters, instruction buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc <= RESET_PC;
         r_rsp_pc   <= RESET_PC;
         r_inflight <= '0;
         r_drop     <= '0;
         r_cnt      <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         r_inflight <= r_inflight + CNT_W'(w_req_hsk) - CNT_W'(i_fch_rsp_vld);
         if (i_redir_vld) begin
            // Everything still outstanding after this cycle is stale.
            r_drop     <= r_inflight - CNT_W'(i_fch_rsp_vld);
            r_fetch_pc <= w_redir_pc;
            r_rsp_pc   <= w_redir_pc;
            r_cnt      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
         end else begin
            if (w_req_hsk) r_fetch_pc <= r_fetch_pc + 32'd4;
            if (i_fch_rsp_vld && (r_drop != '0)) r_drop <= r_drop - CNT_W'(1);
            if (w_push) begin
               r_mem[r_wr_ptr] <= '{pc: r_rsp_pc, ir: i_fch_rsp_data};
               r_wr_ptr        <= ptr_inc(r_wr_ptr);
               r_rsp_pc        <= r_rsp_pc + 32'd4;
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
         end
      end
   end

   // A response must always pair with an outstanding request.
   a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
      i_fch_rsp_vld |-> (r_inflight != '0));

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: bus responder, queue-based reference model,
// directed scenarios and a randomized run with redirects.
module tb_ifu_fetch;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fch_req_vld, fch_req_rdy = 1'b0;
   logic [31:0] fch_req_addr;
   logic        fch_rsp_vld = 1'b0;
   logic [31:0] fch_rsp_data = '0;
   logic        redir_vld = 1'b0;
   logic [31:0] redir_pc = '0;
   logic        iexec_req_vld, iexec_req_rdy = 1'b0;
   logic [31:0] iexec_req_pc, iexec_req_ir;

   always #5 clk = ~clk;

   ifu_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .o_fch_req_vld(fch_req_vld), .i_fch_req_rdy(fch_req_rdy), .o_fch_req_addr(fch_req_addr),
      .i_fch_rsp_vld(fch_rsp_vld), .i_fch_rsp_data(fch_rsp_data),
      .i_redir_vld(redir_vld), .i_redir_pc(redir_pc),
      .o_iexec_req_vld(iexec_req_vld), .i_iexec_req_rdy(iexec_req_rdy),
      .o_iexec_req_pc(iexec_req_pc), .o_iexec_req_ir(iexec_req_ir)
   );

   int tests = 0;
   int fails = 0;

   // Model: outstanding requests (address + stale flag) and buffered packets.
   logic [31:0] pend_addr[$];
   bit          pend_stale[$];
   logic [31:0] xq_pc[$], xq_ir[$];
   logic [31:0] exp_fetch;
   bit          booted;

   logic [31:0] req_log[$], pkt_log[$];
   bit          last_req_vld, last_pkt_hsk;
   logic [31:0] last_req_addr, last_pkt_pc;

   function automatic logic [31:0] memw(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   // One bus cycle, entered at a negedge: drive, check against the model, update it.
   task automatic step(input bit fr, input bit rsp_en, input bit xr, input bit rd,
                       input logic [31:0] rpc);
      bit          rsp, pkt_hsk, exp_vld, s;
      int          used;
      logic [31:0] a;
      fch_req_rdy   = fr;
      iexec_req_rdy = xr;
      redir_vld     = rd;
      redir_pc      = rpc;
      rsp           = rsp_en && (pend_addr.size() != 0);
      fch_rsp_vld   = rsp;
      fch_rsp_data  = rsp ? memw(pend_addr[0]) : $urandom;
      #1;
      pkt_hsk = (xq_pc.size() != 0) && xr;
      used    = pend_addr.size() + xq_pc.size() - (pkt_hsk ? 1 : 0);
      exp_vld = booted && !rd && (used < DEPTH);

      tests++;
      if (iexec_req_vld !== (xq_pc.size() != 0)) begin
         fails++;
         $display("FAIL iexec_vld t=%0t got=%b want=%b", $time, iexec_req_vld, xq_pc.size() != 0);
      end
      if (xq_pc.size() != 0) begin
         tests++;
         if (iexec_req_pc !== xq_pc[0] || iexec_req_ir !== xq_ir[0]) begin
            fails++;
            $display("FAIL iexec_pkt t=%0t got=%h/%h want=%h/%h", $time,
                     iexec_req_pc, iexec_req_ir, xq_pc[0], xq_ir[0]);
         end
      end
      tests++;
      if (fch_req_vld !== exp_vld) begin
         fails++;
         $display("FAIL fch_vld t=%0t got=%b want=%b", $time, fch_req_vld, exp_vld);
      end
      if (exp_vld) begin
         tests++;
         if (fch_req_addr !== exp_fetch) begin
            fails++;
            $display("FAIL fch_addr t=%0t got=%h want=%h", $time, fch_req_addr, exp_fetch);
         end
      end

      last_req_vld  = fch_req_vld;
      last_req_addr = fch_req_addr;
      last_pkt_hsk  = iexec_req_vld && xr;
      last_pkt_pc   = iexec_req_pc;
      if (fch_req_vld && fr) req_log.push_back(fch_req_addr);
      if (iexec_req_vld && xr) pkt_log.push_back(iexec_req_pc);

      if (pkt_hsk) begin
         void'(xq_pc.pop_front());
         void'(xq_ir.pop_front());
      end
      if (rsp) begin
         a = pend_addr.pop_front();
         s = pend_stale.pop_front();
         if (!s && !rd) begin
            xq_pc.push_back(a);
            xq_ir.push_back(memw(a));
         end
      end
      if (exp_vld && fr) begin
         pend_addr.push_back(exp_fetch);
         pend_stale.push_back(1'b0);
         exp_fetch = exp_fetch + 32'd4;
      end
      if (rd) begin
         xq_pc.delete();
         xq_ir.delete();
         foreach (pend_stale[i]) pend_stale[i] = 1'b1;
         exp_fetch = {rpc[31:2], 2'b00};
      end
      booted = 1'b1;
      @(negedge clk);
   endtask

   task automatic clear_logs();
      req_log.delete();
      pkt_log.delete();
   endtask

   // Hold reset one cycle from a negedge, release at the next negedge.
   task automatic do_reset();
      rst_n = 1'b0;
      fch_req_rdy = 1'b0; fch_rsp_vld = 1'b0; redir_vld = 1'b0; iexec_req_rdy = 1'b0;
      pend_addr.delete(); pend_stale.delete(); xq_pc.delete(); xq_ir.delete();
      exp_fetch = RESET_PC;
      booted    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      clear_logs();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      tests++;
      if (fch_req_vld !== 1'b0 || fch_req_addr !== RESET_PC || iexec_req_vld !== 1'b0 ||
          iexec_req_pc !== 32'h0 || iexec_req_ir !== 32'h0) begin
         fails++;
         $display("FAIL reset_outputs got vld=%b addr=%h ivld=%b pc=%h ir=%h want 0/%h/0/0/0",
                  fch_req_vld, fch_req_addr, iexec_req_vld, iexec_req_pc, iexec_req_ir, RESET_PC);
      end
      @(negedge clk);
      do_reset();
      step(1, 1, 1, 0, '0);
      tests++;
      if (last_req_vld !== 1'b0) begin
         fails++;
         $display("FAIL boot_no_req got=%b want=0", last_req_vld);
      end
   endtask

   task automatic test_stream();
      do_reset();
      repeat (12) step(1, 1, 1, 0, '0);
      tests++;
      if (req_log.size() < 3 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4 || req_log[2] !== 32'h8) begin
         fails++;
         $display("FAIL stream_addrs got n=%0d first=%h want 0,4,8", req_log.size(), req_log[0]);
      end
      tests++;
      if (pkt_log.size() != 9 || pkt_log[0] !== 32'h0 || pkt_log[1] !== 32'h4) begin
         fails++;
         $display("FAIL stream_pkts got n=%0d first=%h want n=9 first=0", pkt_log.size(), pkt_log[0]);
      end
   endtask

   task automatic test_exec_stall();
      do_reset();
      repeat (8) step(1, 1, 0, 0, '0);
      tests++;
      if (req_log.size() != 2 || last_req_vld !== 1'b0) begin
         fails++;
         $display("FAIL stall_credit got reqs=%0d vld=%b want reqs=2 vld=0", req_log.size(), last_req_vld);
      end
      clear_logs();
      repeat (4) step(1, 1, 1, 0, '0);
      tests++;
      if (pkt_log.size() < 2 || pkt_log[0] !== 32'h0 || pkt_log[1] !== 32'h4 || req_log[0] !== 32'h8) begin
         fails++;
         $display("FAIL stall_resume got pkt0=%h pkt1=%h req0=%h want 0,4,8", pkt_log[0], pkt_log[1], req_log[0]);
      end
   endtask

   task automatic test_redirect_inflight();
      do_reset();
      repeat (4) step(1, 0, 1, 0, '0);
      step(1, 0, 1, 1, 32'h100);
      tests++;
      if (last_req_vld !== 1'b0 || pend_addr.size() != 2) begin
         fails++;
         $display("FAIL redir_setup got vld=%b inflight=%0d want 0/2", last_req_vld, pend_addr.size());
      end
      clear_logs();
      repeat (8) step(1, 1, 1, 0, '0);
      tests++;
      if (req_log.size() == 0 || req_log[0] !== 32'h100 || pkt_log.size() < 2 ||
          pkt_log[0] !== 32'h100 || pkt_log[1] !== 32'h104) begin
         fails++;
         $display("FAIL redir_inflight got req0=%h pkt0=%h want 100/100", req_log[0], pkt_log[0]);
      end
   endtask

   task automatic test_redirect_same_cycle();
      do_reset();
      step(1, 0, 0, 0, '0);
      step(1, 0, 0, 0, '0);
      step(1, 1, 0, 0, '0);
      step(1, 1, 1, 1, 32'h103);
      tests++;
      if (last_pkt_hsk !== 1'b1 || last_pkt_pc !== 32'h0 || last_req_vld !== 1'b0) begin
         fails++;
         $display("FAIL redir_hsk got hsk=%b pc=%h vld=%b want 1/0/0", last_pkt_hsk, last_pkt_pc, last_req_vld);
      end
      clear_logs();
      repeat (6) step(1, 1, 1, 0, '0);
      tests++;
      if (req_log.size() == 0 || req_log[0] !== 32'h100 || pkt_log.size() == 0 || pkt_log[0] !== 32'h100) begin
         fails++;
         $display("FAIL redir_same got req0=%h pkt0=%h want 100/100", req_log[0], pkt_log[0]);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      step(1, 1, 1, 0, '0);
      step(1, 1, 1, 1, 32'hFFFF_FFFF);
      clear_logs();
      repeat (6) step(1, 1, 1, 0, '0);
      tests++;
      if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin
         fails++;
         $display("FAIL wrap_addrs got %h,%h want fffffffc,0", req_log[0], req_log[1]);
      end
      tests++;
      if (pkt_log.size() < 2 || pkt_log[0] !== 32'hFFFF_FFFC || pkt_log[1] !== 32'h0) begin
         fails++;
         $display("FAIL wrap_pkts got %h,%h want fffffffc,0", pkt_log[0], pkt_log[1]);
      end
   endtask

   task automatic test_bus_stall_and_reset();
      do_reset();
      step(1, 1, 1, 0, '0);
      repeat (5) begin
         step(0, 1, 1, 0, '0);
         tests++;
         if (last_req_vld !== 1'b1 || last_req_addr !== RESET_PC) begin
            fails++;
            $display("FAIL bus_stall got vld=%b addr=%h want 1/%h", last_req_vld, last_req_addr, RESET_PC);
         end
      end
      repeat (6) step(1, 1, 1, 0, '0);
      rst_n = 1'b0;
      fch_rsp_vld = 1'b0; redir_vld = 1'b0;
      #1;
      tests++;
      if (fch_req_vld !== 1'b0 || fch_req_addr !== RESET_PC || iexec_req_vld !== 1'b0 ||
          iexec_req_pc !== 32'h0 || iexec_req_ir !== 32'h0) begin
         fails++;
         $display("FAIL midrun_reset got vld=%b addr=%h ivld=%b pc=%h ir=%h",
                  fch_req_vld, fch_req_addr, iexec_req_vld, iexec_req_pc, iexec_req_ir);
      end
      @(negedge clk);
      do_reset();
      repeat (6) step(1, 1, 1, 0, '0);
      tests++;
      if (req_log.size() == 0 || req_log[0] !== RESET_PC || pkt_log.size() == 0 || pkt_log[0] !== RESET_PC) begin
         fails++;
         $display("FAIL restart got req0=%h pkt0=%h want %h", req_log[0], pkt_log[0], RESET_PC);
      end
   endtask

   task automatic test_random();
      logic [31:0] t;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         t = $urandom;
         if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 24) == 0, t);
      end
      clear_logs();
      repeat (40) step(1, 1, 1, 0, '0);
      tests++;
      if (pkt_log.size() < 30) begin
         fails++;
         $display("FAIL random_drain got pkts=%0d want >=30", pkt_log.size());
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_stream();
      test_exec_stall();
      test_redirect_inflight();
      test_redirect_same_cycle();
      test_wrap();
      test_bus_stall_and_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
